// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, divide latency.
package mdu_pkg;

  localparam int unsigned DivCyclesDefault = 32;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StWb   = 2'd3
  } state_e;

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the pipeline and the multiply/divide controller.
interface mdu_if;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        op_ready;
  logic        busy;
  logic [1:0]  wen_hiol;
  logic [63:0] data_out;

  modport master (
    output op_valid, op_code, src_a, src_b, flush,
    input  op_ready, busy, wen_hiol, data_out
  );

  modport slave (
    input  op_valid, op_code, src_a, src_b, flush,
    output op_ready, busy, wen_hiol, data_out
  );
endinterface

// File: rtl/mdu_div.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// done_o is high during the cycle that produces the final quotient bit.
module mdu_div #(
    parameter int unsigned Cycles = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        cancel_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    localparam int unsigned CntW = $clog2(Cycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     quo_q, quo_d;
    logic [31:0]     rem_q, rem_d;
    logic [31:0]     dsr_q, dsr_d;
    logic [32:0]     shifted;
    logic [33:0]     diff;

    assign shifted = {rem_q, quo_q[31]};
    assign diff    = {1'b0, shifted} - {2'b00, dsr_q};

    always_comb begin
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dsr_d = dsr_q;
        if (start_i) begin
            cnt_d = CntW'(Cycles);
            quo_d = dividend_i;
            rem_d = '0;
            dsr_d = divisor_i;
        end else if (cancel_i) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
            quo_d = {quo_q[30:0], ~diff[33]};
            rem_d = diff[33] ? shifted[31:0] : diff[31:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dsr_q <= dsr_d;
        end
    end

    assign done_o      = (cnt_q == CntW'(1));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide controller: accepts one op at a time, sequences MUL/DIV
// and emits a single write-back cycle with HI/LO enables.
module mdu_ctrl
  import mdu_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DivCyclesDefault
) (
    input logic  clk,
    input logic  rst,
    mdu_if.slave bus
);

    state_e      state_q, state_d;
    logic        accept, op_known, is_mul, is_div, div_zero, sgn;
    logic [32:0] a_q, b_q;
    logic [1:0]  wen_q;
    logic        is_div_q, q_neg_q, r_neg_q;
    logic [63:0] res_q;
    logic signed [65:0] a_ext, b_ext, prod;
    logic [31:0] div_a, div_b, div_quo, div_rem, quo_fix, rem_fix;
    logic        div_done;

    assign op_known = (bus.op_code <= OpMtlo);
    assign is_mul   = (bus.op_code == OpMult) || (bus.op_code == OpMultu);
    assign is_div   = (bus.op_code == OpDiv) || (bus.op_code == OpDivu);
    assign div_zero = (bus.src_b == '0);
    assign sgn      = (bus.op_code == OpMult) || (bus.op_code == OpDiv);
    assign accept   = bus.op_valid && bus.op_ready && op_known;

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) begin
                if (is_mul)                  state_d = StMul;
                else if (is_div && !div_zero) state_d = StDiv;
                else                          state_d = StWb;
            end
            StMul:  state_d = StWb;
            StDiv:  if (div_done) state_d = StWb;
            StWb:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (bus.flush && state_q != StIdle) state_d = StIdle;
    end

    // Magnitudes feed the unsigned divider; signs are restored on the way out.
    assign div_a = (sgn && bus.src_a[31]) ? -bus.src_a : bus.src_a;
    assign div_b = (sgn && bus.src_b[31]) ? -bus.src_b : bus.src_b;

    mdu_div #(
        .Cycles (DIV_CYCLES)
    ) u_div (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (accept && is_div && !div_zero),
        .cancel_i    (bus.flush && state_q != StIdle),
        .dividend_i  (div_a),
        .divisor_i   (div_b),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    assign a_ext = {{33{a_q[32]}}, a_q};
    assign b_ext = {{33{b_q[32]}}, b_q};
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            wen_q    <= '0;
            is_div_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            res_q    <= '0;
        end else begin
            if (accept) begin
                a_q      <= {sgn && bus.src_a[31], bus.src_a};
                b_q      <= {sgn && bus.src_b[31], bus.src_b};
                is_div_q <= is_div;
                q_neg_q  <= sgn && is_div && (bus.src_a[31] ^ bus.src_b[31]);
                r_neg_q  <= sgn && is_div && bus.src_a[31];
                if (bus.op_code == OpMthi)      wen_q <= 2'b01;
                else if (bus.op_code == OpMtlo) wen_q <= 2'b10;
                else if (is_div && div_zero)    wen_q <= 2'b00;
                else                            wen_q <= 2'b11;
                if (!is_mul && !is_div) res_q <= {bus.src_a, bus.src_a};
            end
            if (state_q == StMul) res_q <= prod[63:0];
        end
    end

    assign quo_fix = q_neg_q ? -div_quo : div_quo;
    assign rem_fix = r_neg_q ? -div_rem : div_rem;

    always_comb begin
        bus.op_ready = (state_q == StIdle) && !bus.flush && !rst;
        bus.busy     = (state_q != StIdle) && !rst;
        bus.wen_hiol = (state_q == StWb && !bus.flush && !rst) ? wen_q : 2'b00;
        bus.data_out = res_q;
        if (rst)                               bus.data_out = '0;
        else if (is_div_q && state_q == StWb)  bus.data_out = {rem_fix, quo_fix};
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with hand-computed HI/LO results.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    mdu_if bus ();

    mdu_ctrl #(
        .DIV_CYCLES (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents an op in the current cycle; returns one cycle later with operands scrambled.
    task automatic issue(input string tag, input logic [2:0] code, input logic [31:0] a,
                         input logic [31:0] b);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.src_a    = a;
        bus.src_b    = b;
        #1;
        check_val({tag, " ready"}, 64'(bus.op_ready), 64'd1);
        step();
        bus.op_valid = 1'b0;
        bus.src_a    = ~a;
        bus.src_b    = b ^ 32'h5A5A_0001;
    endtask

    task automatic run_op(input string tag, input logic [2:0] code, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [1:0] ewen,
                          input logic [63:0] edata, input logic [63:0] emask);
        int bad = 0;
        issue(tag, code, a, b);
        for (int i = 1; i < lat; i++) begin
            if (bus.wen_hiol != 2'b00 || !bus.busy) bad++;
            step();
        end
        check_val({tag, " pre-wb"}, 64'(bad), 64'd0);
        check_val({tag, " wen"}, 64'(bus.wen_hiol), 64'(ewen));
        check_val({tag, " data"}, bus.data_out & emask, edata & emask);
        check_val({tag, " wb busy"}, 64'(bus.busy), 64'd1);
        step();
        check_val({tag, " post ready"}, 64'(bus.op_ready), 64'd1);
        check_val({tag, " post wen"}, 64'(bus.wen_hiol), 64'd0);
    endtask

    initial begin
        int bad;
        bus.op_valid = 1'b0;
        bus.op_code  = '0;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.flush    = 1'b0;
        step();
        step();
        check_val("rst ready", 64'(bus.op_ready), 64'd0);
        check_val("rst busy", 64'(bus.busy), 64'd0);
        check_val("rst wen", 64'(bus.wen_hiol), 64'd0);
        check_val("rst data", bus.data_out, 64'd0);
        rst = 1'b0;
        #1;
        check_val("idle ready", 64'(bus.op_ready), 64'd1);

        run_op("mult", OpMult, 32'hFFFF_FFFE, 32'd3, 2, 2'b11, 64'hFFFF_FFFF_FFFF_FFFA, '1);
        run_op("multu", OpMultu, 32'hFFFF_FFFE, 32'd3, 2, 2'b11, 64'h0000_0002_FFFF_FFFA, '1);
        run_op("mult min", OpMult, 32'h8000_0000, 32'h8000_0000, 2, 2'b11,
               64'h4000_0000_0000_0000, '1);
        run_op("div neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 33, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, '1);
        run_op("div negb", OpDiv, 32'd7, 32'hFFFF_FFFE, 33, 2'b11, 64'h0000_0001_FFFF_FFFD, '1);
        run_op("divu", OpDivu, 32'hFFFF_FFFF, 32'd10, 33, 2'b11, 64'h0000_0005_1999_9999, '1);
        run_op("divu zero", OpDivu, 32'd100, 32'd0, 1, 2'b00, 64'd0, 64'd0);
        run_op("div ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 33, 2'b11,
               64'h0000_0000_8000_0000, '1);

        // Flush a divide mid-flight, then an MTLO right behind it.
        issue("flush div", OpDivu, 32'd100, 32'd7);
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (bus.wen_hiol != 2'b00) bad++;
            step();
        end
        bus.flush = 1'b1;
        #1;
        check_val("flush wen", 64'(bus.wen_hiol | 2'(bad)), 64'd0);
        step();
        bus.flush = 1'b0;
        #1;
        check_val("flush ready", 64'(bus.op_ready), 64'd1);
        check_val("flush busy", 64'(bus.busy), 64'd0);
        run_op("mtlo", OpMtlo, 32'hCAFE_F00D, 32'd0, 1, 2'b10, 64'h0000_0000_CAFE_F00D,
               64'h0000_0000_FFFF_FFFF);

        run_op("mthi", OpMthi, 32'h1234_5678, 32'd0, 1, 2'b01, 64'h1234_5678_0000_0000,
               64'hFFFF_FFFF_0000_0000);
        run_op("multu small", OpMultu, 32'd2, 32'd3, 2, 2'b11, 64'd6, '1);

        // Flush coinciding with write-back suppresses the write.
        issue("flush wb", OpMult, 32'd5, 32'd7);
        step();
        bus.flush = 1'b1;
        #1;
        check_val("flush wb wen", 64'(bus.wen_hiol), 64'd0);
        step();
        bus.flush = 1'b0;
        #1;
        check_val("flush wb ready", 64'(bus.op_ready), 64'd1);

        // Reset in the middle of a divide aborts it without a write.
        issue("rst div", OpDiv, 32'd50, 32'd3);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        #1;
        check_val("rst mid wen", 64'(bus.wen_hiol), 64'd0);
        check_val("rst mid ready", 64'(bus.op_ready), 64'd0);
        check_val("rst mid busy", 64'(bus.busy), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check_val("rst drop ready", 64'(bus.op_ready), 64'd1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.wen_hiol != 2'b00 || bus.busy) bad++;
            step();
        end
        check_val("rst no write", 64'(bad), 64'd0);

        // Reserved op code must not start anything.
        bus.op_valid = 1'b1;
        bus.op_code  = 3'd6;
        step();
        bus.op_valid = 1'b0;
        #1;
        check_val("reserved busy", 64'(bus.busy), 64'd0);
        check_val("reserved wen", 64'(bus.wen_hiol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter DIV_CYCLES, default 32: number of divide iteration cycles (one quotient bit per cycle).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 op_valid  in  1  operation request.
REQ-005 op_code  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6,7 reserved.
REQ-006 src_a  in  32  rs operand / dividend / MTHI-MTLO data.
REQ-007 src_b  in  32  rt operand / divisor.
REQ-008 flush  in  1  cancel in-flight op (exception/branch flush).
REQ-009 op_ready  out  1  controller can accept an op this cycle.
REQ-010 busy  out  1  HI/LO update pending; pipeline stalls MFHI/MFLO while high.
REQ-011 wen_hiol  out  2  HI/LO write enables, bit0 = HI, bit1 = LO.
REQ-012 data_out  out  64  HI value in [63:32], LO value in [31:0].

Function
REQ-013 States SHALL be IDLE, MUL, DIV, WB.
REQ-014 An op SHALL be accepted in cycle N when op_valid && op_ready.
- op_ready = (state==IDLE) && !flush && !rst.
- Reserved op_codes SHALL be ignored (no state change).
REQ-015 MTHI/MTLO: IDLE->WB at N+1.
- wen_hiol = 01 (MTHI) or 10 (MTLO).
- src_a SHALL appear in the matching data_out half; the other half is don't-care.
REQ-016 MULT/MULTU: IDLE->MUL (N+1)->WB (N+2).
- wen_hiol = 11 at N+2.
- data_out = 64-bit signed (MULT) or unsigned (MULTU) product.
REQ-017 DIV/DIVU with src_b != 0: IDLE->DIV for DIV_CYCLES cycles (N+1..N+32)->WB (N+33).
- wen_hiol = 11.
- data_out[63:32] = remainder, [31:0] = quotient.
REQ-018 Signed divide: operates on magnitudes.
- Quotient negated when src_a[31]^src_b[31].
- Remainder takes the sign of src_a.
- 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0.
REQ-019 Divide by zero: IDLE->WB at N+1 with wen_hiol = 00; HI/LO SHALL remain unchanged.
REQ-020 WB SHALL last exactly one cycle, then ->IDLE.
- wen_hiol SHALL be 00 in every cycle outside WB.
REQ-021 busy = (state != IDLE).
REQ-022 flush in any non-IDLE state: state ->IDLE next cycle.
- A flush coinciding with WB SHALL force wen_hiol = 00 in that same cycle.
- Partial divide/multiply results SHALL be discarded.
REQ-023 Operands SHALL be captured at acceptance; later src_a/src_b changes SHALL not affect the result.

Reset
REQ-024 While rst is high at a clock edge:
- state <= IDLE; wen_hiol = 00; data_out = 0; busy = 0.
- op_ready SHALL be 0 during the reset cycle.
REQ-025 rst asserted mid-operation SHALL abort the operation with no HI/LO write; op_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-026 Shared package mdu_pkg SHALL hold: op_code constants, state encoding, DIV_CYCLES default.
REQ-027 The iterative restoring divider SHALL be a sub-module mdu_div:
- inputs: start, cancel, unsigned dividend, unsigned divisor.
- outputs: done, quotient, remainder.
- Sign fix-up is done in mdu_ctrl.
REQ-028 Multiply SHALL be a single registered 33x33 signed product stage inside mdu_ctrl (MUL state).

Verification
REQ-029 MULT a=0xFFFFFFFE, b=3 at N -> N+2: wen_hiol=11, data_out=0xFFFFFFFF_FFFFFFFA; busy high N+1..N+2.
REQ-030 MULTU a=0xFFFFFFFE, b=3 -> N+2: data_out=0x00000002_FFFFFFFA.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> wen_hiol=11 only at N+33, data_out=0xFFFFFFFF_FFFFFFFD; op_ready high again at N+34.
REQ-032 DIVU a=100, b=0 -> N+1 WB with wen_hiol=00, op_ready at N+2; also DIV 0x80000000/0xFFFFFFFF -> data_out=0x00000000_80000000.
REQ-033 DIVU 100/7 with flush at N+10 -> no write ever; op_ready at N+11. MTLO 0xCAFEF00D then accepted at N+11 -> wen_hiol=10, data_out[31:0]=0xCAFEF00D at N+12.
REQ-034 MTHI 0x12345678 at N, MULTU 2x3 at N+2 -> N+1 wen_hiol=01 with [63:32]=0x12345678; N+4 data_out=0x00000000_00000006. Also: rst at N+5 of a DIV -> no write; op_ready=1 after rst drops.
